// File: rtl/pll_supervisor_pkg.sv
// Shared types and defaults for the PLL lock supervisor.
// The FSM state encoding lives here so other cores can decode a captured state value.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        StResetPll  = 3'd0,
        StWaitLock  = 3'd1,
        StStabilize = 3'd2,
        StRun       = 3'd3,
        StFail      = 3'd4
    } sup_state_e;

    localparam int unsigned DefRstPulseCycles   = 16;
    localparam int unsigned DefLockStableCycles = 1024;
    localparam int unsigned DefLockTimeoutCycles = 74250;
    localparam int unsigned DefMaxRetries       = 3;

    // Width of a counter that holds 0 .. n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into clk_i.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset pulses, waits for a stable lock, then releases the core reset.
// Retries timed-out lock attempts, gives up into a failed state, and counts lock losses.
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = DefRstPulseCycles,
    parameter int unsigned LOCK_STABLE_CYCLES  = DefLockStableCycles,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = DefLockTimeoutCycles,
    parameter int unsigned MAX_RETRIES         = DefMaxRetries
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       running,
    output logic       failed,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned RstW  = cnt_width(RST_PULSE_CYCLES);
    localparam int unsigned TmoW  = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int unsigned StabW = cnt_width(LOCK_STABLE_CYCLES);

    localparam logic [RstW-1:0]  RstLast  = RstW'(RST_PULSE_CYCLES - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RetryMax = 4'(MAX_RETRIES);

    logic lock_s;

    sync_2ff u_lock_sync (
        .clk_i  (clk_74a),
        .rst_ni (reset_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    sup_state_e       state_q, state_d;
    logic [RstW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [TmoW-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
    logic [3:0]       retry_d;
    logic [7:0]       loss_d;

    always_comb begin
        state_d    = state_q;
        rst_cnt_d  = rst_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        stab_cnt_d = stab_cnt_q;
        retry_d    = retry_count;
        loss_d     = lock_loss_count;

        if (restart_req) begin
            state_d   = StResetPll;
            rst_cnt_d = '0;
            retry_d   = '0;
        end else begin
            case (state_q)
                StResetPll: begin
                    if (rst_cnt_q == RstLast) begin
                        state_d   = StWaitLock;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 1'b1;
                    end
                end
                StWaitLock: begin
                    if (lock_s) begin
                        // The cycle that sees lock already counts towards stability.
                        stab_cnt_d = StabW'(1);
                        state_d    = StStabilize;
                        if (LOCK_STABLE_CYCLES == 1) begin
                            state_d = StRun;
                            retry_d = '0;
                        end
                    end else if (tmo_cnt_q == TmoLast) begin
                        retry_d   = retry_count + 4'd1;
                        rst_cnt_d = '0;
                        state_d   = (retry_d == RetryMax) ? StFail : StResetPll;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 1'b1;
                    end
                end
                StStabilize: begin
                    if (!lock_s) begin
                        state_d   = StWaitLock;
                        tmo_cnt_d = '0;
                    end else if (stab_cnt_q == StabLast) begin
                        state_d = StRun;
                        retry_d = '0;
                    end else begin
                        stab_cnt_d = stab_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (!lock_s) begin
                        state_d   = StResetPll;
                        rst_cnt_d = '0;
                        if (lock_loss_count != 8'hFF) begin
                            loss_d = lock_loss_count + 8'd1;
                        end
                    end
                end
                StFail: begin
                    state_d = StFail;
                end
                default: begin
                    state_d   = StResetPll;
                    rst_cnt_d = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= StResetPll;
            rst_cnt_q       <= '0;
            tmo_cnt_q       <= '0;
            stab_cnt_q      <= '0;
            retry_count     <= '0;
            lock_loss_count <= '0;
            pll_rst         <= 1'b1;
            core_reset_n    <= 1'b0;
            running         <= 1'b0;
            failed          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rst_cnt_q       <= rst_cnt_d;
            tmo_cnt_q       <= tmo_cnt_d;
            stab_cnt_q      <= stab_cnt_d;
            retry_count     <= retry_d;
            lock_loss_count <= loss_d;
            pll_rst         <= (state_d == StResetPll);
            core_reset_n    <= (state_d == StRun);
            running         <= (state_d == StRun);
            failed          <= (state_d == StFail);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench: stimulus queues each expected output change with the cycle it must appear on;
// a monitor pops an entry on every observed change of the output bundle and compares both.
module tb_pll_lock_supervisor;

    logic       clk_74a = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       restart_req;
    logic       pll_rst;
    logic       core_reset_n;
    logic       running;
    logic       failed;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .clk_74a         (clk_74a),
        .reset_n         (reset_n),
        .pll_locked      (pll_locked),
        .restart_req     (restart_req),
        .pll_rst         (pll_rst),
        .core_reset_n    (core_reset_n),
        .running         (running),
        .failed          (failed),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk_74a = ~clk_74a;

    int cyc = 0;
    always @(posedge clk_74a) cyc <= cyc + 1;

    // {pll_rst, core_reset_n, running, failed, retry_count, lock_loss_count}
    logic [15:0] obs;
    assign obs = {pll_rst, core_reset_n, running, failed, retry_count, lock_loss_count};

    typedef struct {
        int          at;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    logic mon_go = 1'b0;

    // flags = {pll_rst, core_reset_n, running, failed}
    task automatic expect_at(input int at, input logic [3:0] flags, input logic [3:0] rc,
                             input logic [7:0] llc);
        exp_t e;
        e.at  = at;
        e.val = {flags, rc, llc};
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got outputs=%h, required %h", name, got, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_74a);
        #2;
    endtask

    initial begin
        wait (mon_go);
        forever begin
            exp_t e;
            @(obs);
            #1;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change: got outputs=%h at cycle %0d, required no change",
                         obs, cyc);
            end else begin
                e = sb.pop_front();
                if (obs !== e.val || cyc != e.at) begin
                    bad++;
                    $display("FAIL output_change: got outputs=%h at cycle %0d, required %h at cycle %0d",
                             obs, cyc, e.val, e.at);
                end
            end
        end
    end

    initial begin
        logic [7:0] llc_v;
        reset_n     = 1'b1;
        pll_locked  = 1'b0;
        restart_req = 1'b0;
        #1 reset_n = 1'b0;
        #1 check("reset_state", obs, 16'h8000);

        // Clean bring-up: lock 10 cycles after release, RUN 8 cycles after lock_s rises.
        step(1);
        reset_n = 1'b1;
        mon_go  = 1'b1;
        expect_at(cyc + 4, 4'b0000, 4'd0, 8'd0);
        step(10);
        pll_locked = 1'b1;
        expect_at(cyc + 10, 4'b0110, 4'd0, 8'd0);
        step(12);

        // Repeated lock loss in RUN; count saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            llc_v = (i > 255) ? 8'd255 : 8'(i);
            pll_locked = 1'b0;
            expect_at(cyc + 3, 4'b1000, 4'd0, llc_v);
            expect_at(cyc + 7, 4'b0000, 4'd0, llc_v);
            expect_at(cyc + 15, 4'b0110, 4'd0, llc_v);
            step(1);
            pll_locked = 1'b1;
            step(15);
        end

        // One-cycle glitch at stable count 5 forces a fresh 8-cycle stability window.
        pll_locked = 1'b0;
        expect_at(cyc + 3, 4'b1000, 4'd0, 8'd255);
        expect_at(cyc + 7, 4'b0000, 4'd0, 8'd255);
        expect_at(cyc + 26, 4'b0110, 4'd0, 8'd255);
        step(10);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(12);

        // Lock never returns: two timed-out attempts, then FAIL.
        pll_locked = 1'b0;
        expect_at(cyc + 3, 4'b1000, 4'd0, 8'd255);
        expect_at(cyc + 7, 4'b0000, 4'd0, 8'd255);
        expect_at(cyc + 39, 4'b1000, 4'd1, 8'd255);
        expect_at(cyc + 43, 4'b0000, 4'd1, 8'd255);
        expect_at(cyc + 75, 4'b0001, 4'd2, 8'd255);
        step(80);

        // Restart out of FAIL, then async reset in the middle of STABILIZE.
        restart_req = 1'b1;
        expect_at(cyc + 1, 4'b1000, 4'd0, 8'd255);
        expect_at(cyc + 5, 4'b0000, 4'd0, 8'd255);
        step(1);
        restart_req = 1'b0;
        step(5);
        pll_locked = 1'b1;
        step(5);
        expect_at(cyc, 4'b1000, 4'd0, 8'd0);
        reset_n = 1'b0;
        #1 check("async_reset", obs, 16'h8000);
        step(3);
        reset_n = 1'b1;
        expect_at(cyc + 4, 4'b0000, 4'd0, 8'd0);
        expect_at(cyc + 12, 4'b0110, 4'd0, 8'd0);
        step(14);

        // Restart and lock loss on the same edge: restart wins, no loss counted.
        pll_locked = 1'b0;
        step(2);
        restart_req = 1'b1;
        expect_at(cyc + 1, 4'b1000, 4'd0, 8'd0);
        expect_at(cyc + 5, 4'b0000, 4'd0, 8'd0);
        step(1);
        restart_req = 1'b0;
        step(8);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d expected changes never observed, required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset attempt (minimum 1).
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: number of consecutive locked cycles required before core reset release (minimum 1).
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 74250: number of cycles to wait for lock before a reset attempt is retried (minimum 2).
REQ-004 Parameter MAX_RETRIES, default 3: number of timed-out attempts before entering FAIL (range 1..15).
REQ-005 Port clk_74a, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port pll_locked, input, 1 bit: PLL locked indication; asynchronous to clk_74a.
REQ-008 Port restart_req, input, 1 bit: synchronous single-cycle request to re-initialise the PLL.
REQ-009 Port pll_rst, output, 1 bit: drives the PLL rst input; active-high.
REQ-010 Port core_reset_n, output, 1 bit: reset for logic on PLL output clocks; active-low.
REQ-011 Port running, output, 1 bit: high while in RUN.
REQ-012 Port failed, output, 1 bit: high while in FAIL.
REQ-013 Port retry_count, output, 4 bits: number of timed-out attempts in the current bring-up.
REQ-014 Port lock_loss_count, output, 8 bits: saturating count of lock losses seen while in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer to produce lock_s; the FSM SHALL use only lock_s.
REQ-016 FSM states SHALL be RESET_PLL, WAIT_LOCK, STABILIZE, RUN and FAIL; all outputs SHALL be registered and decoded from the next state.
REQ-017 RESET_PLL: pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then the FSM SHALL go to WAIT_LOCK with the timeout counter cleared.
REQ-018 WAIT_LOCK: if lock_s=1, the FSM SHALL go to STABILIZE.
REQ-019 WAIT_LOCK: otherwise, on the LOCK_TIMEOUT_CYCLES-th cycle, retry_count SHALL increment; if the new value equals MAX_RETRIES the FSM SHALL go to FAIL, else to RESET_PLL.
REQ-020 STABILIZE: the stable counter SHALL count cycles with lock_s=1.
REQ-021 STABILIZE: any lock_s=0 SHALL return the FSM to WAIT_LOCK with the timeout counter cleared; retry_count is unchanged.
REQ-022 STABILIZE: after LOCK_STABLE_CYCLES consecutive locked cycles, the FSM SHALL go to RUN and retry_count SHALL clear.
REQ-023 RUN: core_reset_n=1 and running=1.
REQ-024 RUN: lock_s=0 SHALL increment lock_loss_count (saturating at 255), deassert core_reset_n and running on the next edge, and go to RESET_PLL.
REQ-025 FAIL: pll_rst=0, core_reset_n=0, failed=1; FAIL is exited only via restart_req.
REQ-026 restart_req=1 in any state SHALL go to RESET_PLL and clear retry_count; it has priority over every other transition on the same cycle; lock_loss_count is preserved.
REQ-027 core_reset_n SHALL be 0 in every state except RUN; pll_rst SHALL be 1 only in RESET_PLL.
REQ-028 Counters SHALL be sized by $clog2 of their parameter; none SHALL wrap.

Reset
REQ-029 While reset_n=0, all flops SHALL clear asynchronously: state=RESET_PLL, pll_rst=1, core_reset_n=0, running=0, failed=0, retry_count=0, lock_loss_count=0, synchronizer=0.
REQ-030 After reset_n rises, the first RESET_PLL pulse SHALL last the full RST_PULSE_CYCLES cycles.
REQ-031 Reset asserted mid-operation SHALL abort any state immediately, with no partial pulse continuation.

Structure
REQ-032 The state enumeration and default parameter constants SHALL live in the shared package pll_supervisor_pkg.
REQ-033 The 2-flop synchronizer SHALL be a separate sub-module, sync_2ff, which other cores can reuse.

Verification
All scenarios use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32 and MAX_RETRIES=2.
REQ-034 Clean bring-up: release reset_n, then raise pll_locked 10 cycles later -> pll_rst high for 4 cycles; core_reset_n rises 8 cycles after lock_s rises; running=1; retry_count=0.
REQ-035 Timeout to FAIL: pll_locked stays 0 -> two 4-cycle pll_rst pulses separated by 32 cycles; retry_count=1 and then 2; failed=1 with pll_rst=0.
REQ-036 Glitch during STABILIZE: drop pll_locked for 1 cycle at stable count 5 -> FSM returns to WAIT_LOCK; core_reset_n is released only after a fresh 8 consecutive locked cycles.
REQ-037 Lock loss in RUN: drop pll_locked -> within 3 cycles core_reset_n=0, lock_loss_count=1, and a new 4-cycle pll_rst pulse; force 300 losses -> count saturates at 255.
REQ-038 Restart and async reset: pulse restart_req in FAIL -> RESET_PLL with retry_count=0; assert reset_n mid-STABILIZE -> all outputs take reset values combinationally, without waiting for a clock edge.
